// File: rtl/seq_arb_pkg.sv
// seq_arb_pkg
//   Shared types and helpers for the sequence-item arbiter:
//   arbitration mode and FSM state enums, plus a saturating increment
//   used by the per-requester waiting-age counters.
package seq_arb_pkg;

  typedef enum logic [1:0] {
    ARB_FIFO        = 2'd0,
    ARB_STRICT_FIFO = 2'd1,
    ARB_RR          = 2'd2
  } arb_mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_GRANT = 2'd2
  } arb_state_e;

  // Wide enough for any supported age width; callers cast in and out.
  localparam int SAT_W = 16;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/seq_arb_pick.sv
// seq_arb_pick
//   Combinational winner select among eligible requesters.
//   Ports:
//     eligible  in   NREQ        requesters allowed to win this cycle
//     prio      in   NREQ*PW     priority per requester, [i*PW+:PW]
//     ages      in   NREQ*AGE_W  waiting age per requester, [i*AGE_W+:AGE_W]
//     rr_ptr    in   IDW         round-robin start index
//     mode      in   arb_mode_e  selection rule
//     win_id    out  IDW         selected requester (don't-care when !any)
//     any       out  1           at least one requester is eligible
module seq_arb_pick
  import seq_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PW    = 3,
  parameter int AGE_W = 6,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]       eligible,
  input  logic [NREQ*PW-1:0]    prio,
  input  logic [NREQ*AGE_W-1:0] ages,
  input  logic [IDW-1:0]        rr_ptr,
  input  arb_mode_e             mode,
  output logic [IDW-1:0]        win_id,
  output logic                  any
);

  logic             found;
  logic             better;
  logic [PW-1:0]    best_p;
  logic [AGE_W-1:0] best_a;
  logic [PW-1:0]    cur_p;
  logic [AGE_W-1:0] cur_a;
  int               rr_sum;
  logic [IDW-1:0]   rr_idx;

  always_comb begin
    win_id = '0;
    any    = |eligible;
    found  = 1'b0;
    better = 1'b0;
    best_p = '0;
    best_a = '0;
    cur_p  = '0;
    cur_a  = '0;
    rr_sum = 0;
    rr_idx = '0;
    if (mode == ARB_RR) begin
      // Walk from farthest to nearest so the last hit is the first eligible
      // index at or after rr_ptr.
      for (int k = NREQ - 1; k >= 0; k--) begin
        rr_sum = int'(rr_ptr) + k;
        if (rr_sum >= NREQ) rr_sum = rr_sum - NREQ;
        rr_idx = IDW'(rr_sum);
        if (eligible[rr_idx]) win_id = rr_idx;
      end
    end else begin
      // Strict '>' keeps the lowest index on ties.
      for (int i = 0; i < NREQ; i++) begin
        cur_p = prio[i*PW +: PW];
        cur_a = ages[i*AGE_W +: AGE_W];
        if (mode == ARB_STRICT_FIFO)
          better = !found || (cur_p > best_p) || ((cur_p == best_p) && (cur_a > best_a));
        else
          better = !found || (cur_a > best_a);
        if (eligible[i] && better) begin
          found  = 1'b1;
          best_p = cur_p;
          best_a = cur_a;
          win_id = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/seq_item_arbiter.sv
// seq_item_arbiter
//   Shares one driver port between NREQ sequence requesters with FIFO,
//   strict-priority-FIFO or round-robin selection and lock/grab exclusivity.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     arb_mode        selection rule (3 behaves as FIFO), used in ARB only
//     req_valid       requester has an item pending
//     req_prio        per-requester priority, [i*PW+:PW]
//     req_lock        per-requester exclusive-access request
//     drv_get         driver wants an item (level)
//     drv_item_done   driver finished the current item (pulse)
//     gnt_valid       grant outstanding
//     gnt_id          granted requester
//     gnt_onehot      one-hot of gnt_id, zero when no grant
//     locked          lock held
//     lock_owner      lock owner, meaningful while locked
//     err_done        pulse: item_done arrived with no grant outstanding
//
//   state   | meaning
//   S_IDLE  | driver not asking; no grant
//   S_ARB   | driver asking; pick a winner as soon as one is eligible
//   S_GRANT | grant held stable until drv_item_done
module seq_item_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PW    = 3,
  parameter int AGE_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                arb_mode,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*PW-1:0]        req_prio,
  input  logic [NREQ-1:0]           req_lock,
  input  logic                      drv_get,
  input  logic                      drv_item_done,
  output logic                      gnt_valid,
  output logic [$clog2(NREQ)-1:0]   gnt_id,
  output logic [NREQ-1:0]           gnt_onehot,
  output logic                      locked,
  output logic [$clog2(NREQ)-1:0]   lock_owner,
  output logic                      err_done
);

  localparam int IDW     = $clog2(NREQ);
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  arb_state_e           state_q, state_d;
  arb_mode_e            mode_eff;
  logic [AGE_W-1:0]     age_q [NREQ];
  logic [NREQ*AGE_W-1:0] ages_flat;
  logic [NREQ-1:0]      eligible;
  logic [NREQ-1:0]      granted;
  logic [IDW-1:0]       win_id;
  logic                 any;
  logic                 arb_fire;
  logic                 done_grant;
  logic [IDW-1:0]       rr_ptr_q;
  logic                 gnt_valid_q;
  logic [IDW-1:0]       gnt_id_q;
  logic                 gnt_lock_q;
  logic                 locked_q;
  logic [IDW-1:0]       lock_owner_q;
  logic                 err_done_q;

  always_comb begin
    case (arb_mode)
      2'd1:    mode_eff = ARB_STRICT_FIFO;
      2'd2:    mode_eff = ARB_RR;
      default: mode_eff = ARB_FIFO;
    endcase
  end

  always_comb begin
    ages_flat = '0;
    for (int i = 0; i < NREQ; i++) ages_flat[i*AGE_W +: AGE_W] = age_q[i];
  end

  assign eligible = req_valid & (locked_q ? (NREQ'(1) << lock_owner_q) : {NREQ{1'b1}});

  seq_arb_pick #(
    .NREQ  (NREQ),
    .PW    (PW),
    .AGE_W (AGE_W),
    .IDW   (IDW)
  ) u_pick (
    .eligible (eligible),
    .prio     (req_prio),
    .ages     (ages_flat),
    .rr_ptr   (rr_ptr_q),
    .mode     (mode_eff),
    .win_id   (win_id),
    .any      (any)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    arb_fire   = 1'b0;
    done_grant = 1'b0;
    case (state_q)
      S_IDLE: if (drv_get) state_d = S_ARB;
      S_ARB: begin
        if (any) begin
          arb_fire = 1'b1;
          state_d  = S_GRANT;
        end else if (!drv_get) begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (drv_item_done) begin
          done_grant = 1'b1;
          state_d    = drv_get ? S_ARB : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The requester being selected this cycle, or holding the grant, does not age.
  always_comb begin
    granted = '0;
    for (int i = 0; i < NREQ; i++)
      granted[i] = ((state_q == S_GRANT) && (gnt_id_q == IDW'(i))) ||
                   (arb_fire && (win_id == IDW'(i)));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || !req_valid[i] || granted[i]) age_q[i] <= '0;
      else age_q[i] <= AGE_W'(sat_inc(SAT_W'(age_q[i]), SAT_W'(AGE_MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_id_q     <= '0;
      gnt_lock_q   <= 1'b0;
      locked_q     <= 1'b0;
      lock_owner_q <= '0;
      err_done_q   <= 1'b0;
    end else begin
      err_done_q <= drv_item_done && (state_q != S_GRANT);
      if (arb_fire) begin
        gnt_valid_q <= 1'b1;
        gnt_id_q    <= win_id;
        gnt_lock_q  <= req_lock[win_id];
      end
      if (done_grant) begin
        gnt_valid_q <= 1'b0;
        rr_ptr_q    <= (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
      end
      // A lock taken at this done wins over a release seen in the same cycle.
      if (locked_q && !req_lock[lock_owner_q]) locked_q <= 1'b0;
      if (done_grant && gnt_lock_q) begin
        locked_q     <= 1'b1;
        lock_owner_q <= gnt_id_q;
      end
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_id     = gnt_id_q;
  assign gnt_onehot = gnt_valid_q ? (NREQ'(1) << gnt_id_q) : '0;
  assign locked     = locked_q;
  assign lock_owner = lock_owner_q;
  assign err_done   = err_done_q;

endmodule
